// File: rtl/conv_mac_driver.sv
// Drives one mac_generic through a KxK window per pixel burst and holds the
// finished dot product on a valid/ready result port, with optional ReLU.
//
// state | meaning
// IDLE  | waiting for the first pixel; weight writes accepted here only
// CLR   | clear the MAC accumulator, rewind the tap counter
// FEED  | accept N pixels, pair each with w[tap]; stalls feed zeros
// FLUSH | last product drains from the MAC product stage into the sum
// OUT   | MAC registers its sum onto Y
// CAP   | capture Y (ReLU applied) into the result register
// HOLD  | result offered downstream until accepted
module conv_mac_driver #(
  parameter  int I_W   = 8,
  parameter  int K     = 3,
  parameter  int ACC_W = 2*I_W+2,
  localparam int N     = K*K,
  localparam int CW    = (N > 1) ? $clog2(N) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    w_we_i,
  input  logic [CW-1:0]           w_addr_i,
  input  logic signed [I_W-1:0]   w_data_i,
  input  logic                    pix_valid_i,
  input  logic signed [I_W-1:0]   pix_data_i,
  output logic                    pix_ready_o,
  input  logic                    relu_en_i,
  output logic                    mac_clr_o,
  output logic                    mac_en_o,
  output logic                    mac_en_out_o,
  output logic signed [I_W-1:0]   mac_a_o,
  output logic signed [I_W-1:0]   mac_b_o,
  input  logic signed [ACC_W-1:0] mac_y_i,
  output logic                    res_valid_o,
  output logic signed [ACC_W-1:0] res_data_o,
  input  logic                    res_ready_i
);

  typedef enum logic [2:0] {
    S_IDLE, S_CLR, S_FEED, S_FLUSH, S_OUT, S_CAP, S_HOLD
  } state_t;

  state_t                  state_q, state_d;
  logic [CW-1:0]           tap_cnt_q, tap_cnt_d;
  logic signed [I_W-1:0]   w_q [N];
  logic signed [ACC_W-1:0] res_q, res_d;
  logic                    w_wr;

  // Weights are frozen while a window is in flight so every tap of a window
  // sees the same kernel.
  assign w_wr = (state_q == S_IDLE) && w_we_i && (w_addr_i <= CW'(N-1));

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      tap_cnt_q <= '0;
      res_q     <= '0;
      for (int i = 0; i < N; i++) w_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      tap_cnt_q <= tap_cnt_d;
      res_q     <= res_d;
      if (w_wr) w_q[w_addr_i] <= w_data_i;
    end
  end

  always_comb begin
    state_d      = state_q;
    tap_cnt_d    = tap_cnt_q;
    res_d        = res_q;
    pix_ready_o  = 1'b0;
    mac_clr_o    = 1'b0;
    mac_en_o     = 1'b0;
    mac_en_out_o = 1'b0;
    mac_a_o      = '0;
    mac_b_o      = '0;
    res_valid_o  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (pix_valid_i) state_d = S_CLR;
      end
      S_CLR: begin
        mac_clr_o = 1'b1;
        tap_cnt_d = '0;
        state_d   = S_FEED;
      end
      S_FEED: begin
        pix_ready_o = 1'b1;
        // A stalled cycle leaves A/B at zero so the MAC accumulates nothing.
        if (pix_valid_i) begin
          mac_en_o = 1'b1;
          mac_a_o  = pix_data_i;
          mac_b_o  = w_q[tap_cnt_q];
          if (tap_cnt_q == CW'(N-1)) begin
            tap_cnt_d = '0;
            state_d   = S_FLUSH;
          end else begin
            tap_cnt_d = tap_cnt_q + CW'(1);
          end
        end
      end
      S_FLUSH: begin
        state_d = S_OUT;
      end
      S_OUT: begin
        mac_en_out_o = 1'b1;
        state_d      = S_CAP;
      end
      S_CAP: begin
        res_d   = (relu_en_i && (mac_y_i < 0)) ? '0 : mac_y_i;
        state_d = S_HOLD;
      end
      S_HOLD: begin
        res_valid_o = 1'b1;
        if (res_ready_i) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign res_data_o = res_q;

endmodule

// File: tb/tb_conv_mac_driver.sv
// Bench for conv_mac_driver: a cycle model of the MAC closes the loop, and the
// expected result of each window is the plain dot product of weights and pixels.
module tb_conv_mac_driver;
  localparam int I_W   = 8;
  localparam int K     = 3;
  localparam int N     = K*K;
  localparam int ACC_W = 2*I_W+2;
  localparam int CW    = $clog2(N);

  typedef logic signed [I_W-1:0] win_t [N];

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic                    w_we;
  logic [CW-1:0]           w_addr;
  logic signed [I_W-1:0]   w_data;
  logic                    pix_valid;
  logic signed [I_W-1:0]   pix_data;
  logic                    pix_ready;
  logic                    relu_en;
  logic                    mac_clr, mac_en, mac_en_out;
  logic signed [I_W-1:0]   mac_a, mac_b;
  logic signed [ACC_W-1:0] mac_y;
  logic                    res_valid;
  logic signed [ACC_W-1:0] res_data;
  logic                    res_ready;

  conv_mac_driver #(.I_W(I_W), .K(K), .ACC_W(ACC_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .w_we_i       (w_we),
    .w_addr_i     (w_addr),
    .w_data_i     (w_data),
    .pix_valid_i  (pix_valid),
    .pix_data_i   (pix_data),
    .pix_ready_o  (pix_ready),
    .relu_en_i    (relu_en),
    .mac_clr_o    (mac_clr),
    .mac_en_o     (mac_en),
    .mac_en_out_o (mac_en_out),
    .mac_a_o      (mac_a),
    .mac_b_o      (mac_b),
    .mac_y_i      (mac_y),
    .res_valid_o  (res_valid),
    .res_data_o   (res_data),
    .res_ready_i  (res_ready)
  );

  // MAC: product stage, accumulate stage, output register zeroed when not loading.
  logic signed [ACC_W-1:0] t1, t2, prod;
  assign prod = ACC_W'(mac_a) * ACC_W'(mac_b);
  always @(posedge clk) begin
    if (!rst) begin
      t1 <= '0; t2 <= '0; mac_y <= '0;
    end else begin
      if (mac_clr) begin
        t1 <= '0; t2 <= '0;
      end else begin
        t1 <= mac_en ? prod : '0;
        t2 <= t2 + t1;
      end
      mac_y <= mac_en_out ? t2 : '0;
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;
  int wm [N];
  logic signed [ACC_W-1:0] exp_q [$];
  int tap_idx = 0, en_cnt = 0, clr_cnt = 0, eo_cnt = 0;
  logic hold_prev = 1'b0;
  logic signed [ACC_W-1:0] hold_val;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic signed [ACC_W-1:0] model(input win_t px, input logic relu);
    longint s = 0;
    logic signed [ACC_W-1:0] r;
    for (int i = 0; i < N; i++) s += longint'(wm[i]) * longint'(px[i]);
    r = s[ACC_W-1:0];
    if (relu && r < 0) r = '0;
    return r;
  endfunction

  // Per-cycle protocol checks and result scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      tap_idx   = 0;
      hold_prev = 1'b0;
    end else begin
      check("mac_en_vs_accept", mac_en, pix_valid & pix_ready);
      if (mac_en) begin
        check("mac_a", mac_a, pix_data);
        check("mac_b", mac_b, wm[tap_idx]);
        tap_idx = (tap_idx + 1) % N;
        en_cnt++;
      end else begin
        check("mac_ab_zero", {mac_a, mac_b}, 0);
      end
      if (mac_clr) clr_cnt++;
      if (mac_en_out) eo_cnt++;
      if (res_valid) begin
        check("pix_ready_in_hold", pix_ready, 0);
        if (hold_prev) check("res_stable", res_data, hold_val);
        hold_val  = res_data;
        hold_prev = 1'b1;
        if (res_ready) begin
          checks++;
          if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_result: got %0d expected none", res_data);
          end else begin
            logic signed [ACC_W-1:0] e;
            e = exp_q.pop_front();
            if (res_data !== e) begin
              failures++;
              $display("FAIL res_model: got %0d expected %0d", res_data, e);
            end
          end
          hold_prev = 1'b0;
        end
      end else begin
        hold_prev = 1'b0;
      end
    end
  end

  task automatic align();
    @(posedge clk); #1;
  endtask

  task automatic write_w(input int addr, input int val);
    w_we = 1'b1; w_addr = CW'(addr); w_data = I_W'(val);
    align();
    w_we = 1'b0;
    wm[addr] = val;
  endtask

  task automatic load_all(input int val);
    align();
    for (int i = 0; i < N; i++) write_w(i, val);
  endtask

  task automatic feed(input win_t px, input int stall_at, input int stall_len,
                      input int wr_at, input int abort_at);
    int k = 0, g = 0, s = 0;
    logic wr_done = 1'b0, stop = 1'b0;
    pix_valid = 1'b1; pix_data = px[0];
    while (!stop && k < N && g < 200) begin
      @(negedge clk);
      g++;
      if (pix_valid && pix_ready) k++;
      align();
      w_we = 1'b0;
      if (k == abort_at) begin
        rst = 1'b0; pix_valid = 1'b0; pix_data = '0; stop = 1'b1;
      end else if (k == stall_at && s < stall_len) begin
        pix_valid = 1'b0; pix_data = '0; s++;
      end else if (k < N) begin
        pix_valid = 1'b1; pix_data = px[k];
      end else begin
        pix_valid = 1'b0; pix_data = '0;
      end
      if (!stop && k == wr_at && !wr_done) begin
        w_we = 1'b1; w_addr = CW'(N-1); w_data = I_W'(5); wr_done = 1'b1;
      end
    end
    if (!stop) check("feed_done", k, N);
  endtask

  task automatic wait_valid(input int t0, output int lat);
    int g = 0;
    @(negedge clk);
    while (!res_valid && g < 100) begin
      @(negedge clk);
      g++;
    end
    lat = res_valid ? (cyc - t0) : -1;
  endtask

  task automatic window(input win_t px, input logic relu, input int stall_at,
                        input int stall_len, input int wr_at,
                        output int lat, output longint res);
    int t0;
    align();
    exp_q.push_back(model(px, relu));
    en_cnt = 0; clr_cnt = 0; eo_cnt = 0;
    relu_en = relu;
    t0 = cyc;
    feed(px, stall_at, stall_len, wr_at, -1);
    wait_valid(t0, lat);
    res = res_data;
  endtask

  function automatic longint outs_vec();
    logic [38:0] v;
    v = {pix_ready, mac_clr, mac_en, mac_en_out, mac_a, mac_b, res_valid, res_data};
    return longint'(v);
  endfunction

  win_t lin, dbl;
  int lat;
  longint res;

  initial begin
    for (int i = 0; i < N; i++) begin
      lin[i] = I_W'(i + 1);
      dbl[i] = I_W'(2 * (i + 1));
      wm[i]  = 0;
    end
    w_we = 1'b0; w_addr = '0; w_data = '0;
    pix_valid = 1'b0; pix_data = '0; relu_en = 1'b0; res_ready = 1'b1;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", outs_vec(), 0);
    align();
    rst = 1'b1;

    // Basic window: 1..9 against all-ones kernel.
    load_all(1);
    window(lin, 1'b0, -1, 0, -1, lat, res);
    check("basic_res", res, 45);
    check("basic_latency", lat, 14);
    check("basic_en_cycles", en_cnt, 9);
    check("basic_clr_cycles", clr_cnt, 1);
    check("basic_en_out_cycles", eo_cnt, 1);

    // Three-cycle stall after the fourth tap.
    window(lin, 1'b0, 4, 3, -1, lat, res);
    check("stall_res", res, 45);
    check("stall_latency", lat, 17);
    check("stall_en_cycles", en_cnt, 9);

    // Negative kernel, with and without ReLU.
    load_all(-1);
    window(lin, 1'b0, -1, 0, -1, lat, res);
    check("neg_res", res, -45);
    check("neg_bits", res & 64'h3FFFF, 64'h3FFD3);
    window(lin, 1'b1, -1, 0, -1, lat, res);
    check("relu_res", res, 0);
    relu_en = 1'b0;

    // Backpressure: result held five cycles while a producer waits.
    load_all(1);
    res_ready = 1'b0;
    window(lin, 1'b0, -1, 0, -1, lat, res);
    check("bp_first", res, 45);
    pix_valid = 1'b1; pix_data = I_W'(2);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_valid", res_valid, 1);
      check("bp_data", res_data, 45);
      check("bp_pix_ready", pix_ready, 0);
      align();
    end
    res_ready = 1'b1; pix_valid = 1'b0; pix_data = '0;
    window(dbl, 1'b0, -1, 0, -1, lat, res);
    check("bp_next_res", res, 90);
    check("bp_next_latency", lat, 14);

    // Reset after the fifth tap abandons the window and clears the kernel.
    align();
    relu_en = 1'b0;
    feed(lin, -1, 0, -1, 5);
    @(posedge clk);
    for (int i = 0; i < N; i++) wm[i] = 0;
    @(negedge clk);
    check("midreset_outputs", outs_vec(), 0);
    align();
    rst = 1'b1;
    window(lin, 1'b0, -1, 0, -1, lat, res);
    check("noreload_res", res, 0);
    load_all(1);
    window(lin, 1'b0, -1, 0, -1, lat, res);
    check("reload_res", res, 45);

    // A weight write during FEED is dropped; the same write in IDLE lands.
    window(lin, 1'b0, -1, 0, 2, lat, res);
    check("feed_write_ignored", res, 45);
    align();
    write_w(N-1, 5);
    window(lin, 1'b0, -1, 0, -1, lat, res);
    check("idle_write_applied", res, 81);

    repeat (3) @(negedge clk);
    check("results_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
